id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Parametrised ID/EX pipeline register for the five-stage MIPS datapath, between the decode stage (register file, sign extender, control unit) and the execute stage (ALU, forwarding muxes). It captures the decoded operands, register specifiers, PC and the WB/M/EX control groups, and adds what the earlier fixed-width register lacked:
- a valid bit;
- stall (hold) for load-use hazards;
- flush (bubble insertion) for taken branches/jumps;
- saturating stall/flush performance counters.

## Interface
Parameters:
- DATA_W, 32, width of PC, read data and sign-extended immediate
- REG_W, 5, register specifier width
- WB_W, 2, WB control group width
- M_W, 3, M control group width
- EX_W, 4, EX control group width
- CNT_W, 16, performance counter width

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high
- Stall  in  1  hold all pipeline state this cycle
- Flush  in  1  replace register contents with a bubble
- CountClr  in  1  synchronous clear of both counters
- Valid_in  in  1  decode-stage instruction is valid
- PC_in  in  DATA_W  PC+4 of decoded instruction
- ReadData1_in, ReadData2_in  in  DATA_W  register file outputs
- SignExtend_in  in  DATA_W  extended immediate
- Rs_in, Rt_in, Rd_in  in  REG_W  instruction fields
- ControlWB_in  in  WB_W  write-back controls
- ControlM_in  in  M_W  memory controls
- ControlEX_in  in  EX_W  execute controls
- Valid_out  out  1  registered valid
- PC_out, ReadData1_out, ReadData2_out, SignExtend_out  out  DATA_W  registered copies
- Rs_out, Rt_out, Rd_out  out  REG_W  registered copies
- ControlWB_out, ControlM_out, ControlEX_out  out  WB_W/M_W/EX_W  registered controls
- StallCount  out  CNT_W  cycles spent stalled
- FlushCount  out  CNT_W  bubbles inserted by Flush

## Operation
- Reset (Rst=1, asynchronous): every output, including both counters, goes to 0 immediately and stays 0 while Rst is asserted.
- Each rising Clk, priority is Flush > Stall > load:
  - Flush=1: Valid_out←0; all control groups←0; all data/specifier fields←0. Applies regardless of Stall.
  - Stall=1, Flush=0: every field holds its value, including Valid_out.
  - Otherwise, load:
    - All data and specifier fields load from their inputs.
    - Valid_out←Valid_in.
    - If Valid_in=1, the control groups load from their inputs.
    - If Valid_in=0, the control groups are forced to 0, so an invalid instruction never writes a register or memory.
- Counters:
  - CountClr=1 clears both counters, overriding any increment in the same cycle.
  - Otherwise StallCount increments on each cycle with Stall=1 and Flush=0.
  - Otherwise FlushCount increments on each cycle with Flush=1.
  - Both counters saturate at 2^CNT_W−1; they never wrap.
  - Counters are unaffected by Valid_in.
- Invariant: Valid_out=0 implies ControlWB_out, ControlM_out and ControlEX_out are all 0.

## Timing
- Latency of 1 cycle from input to output when neither Stall nor Flush is asserted.
- Stall for N consecutive cycles freezes the outputs for N cycles. The input present on the first non-stalled edge is the one captured.
- Flush takes effect at the same edge it is sampled. A bubble persists through any following stalled cycles.
- Rst deassertion mid-operation: the first rising edge after release behaves as a normal load, flush or stall.
- No combinational path from any input to any output.

## Structure
- Shared package `mips_pipe_pkg` holds:
  - the default widths (DATA_W, REG_W, WB_W, M_W, EX_W);
  - the bit positions of RegWrite/MemtoReg in the WB group, MemRead/MemWrite/Branch in the M group, and RegDst/ALUSrc/ALUOp in the EX group.
- Sub-module `pipe_field_reg` (parameter W; ports Clk, Rst, En, Clr, D, Q) provides a register with async reset, synchronous clear and enable.
  - The top level instantiates one per field group:
    - data fields: Clr=Flush, En=!Stall;
    - control groups: Clr=Flush|(!Valid_in&!Stall), En=!Stall;
    - Valid_out: one single-bit instance, D=Valid_in, Clr=Flush, En=!Stall.
  - The two counters stay in the top level.

## Test plan
- Reset: drive all inputs to nonzero, pulse Rst mid-cycle → all outputs read 0 before the next edge; the first edge after release loads PC_in=0x00000010 to PC_out=0x00000010.
- Pass-through: Valid_in=1, ReadData1_in=0xDEADBEEF, Rt_in=9, ControlWB_in=2'b11 → visible on the outputs one cycle later, Valid_out=1.
- Stall: load PC 0x20, then Stall=1 for 3 cycles while PC_in changes to 0x24/0x28/0x2C → PC_out stays 0x20, StallCount=3; release captures 0x2C.
- Flush vs. stall: Stall=1 and Flush=1 together → Valid_out=0, controls=0, data=0, FlushCount increments, StallCount unchanged.
- Invalid instruction: Valid_in=0, ControlM_in=3'b010 → ControlM_out=0, ReadData2_out still loads its input.
- Saturation: CNT_W=2, hold Stall for 6 cycles → StallCount reaches 3 and stays at 3; CountClr=1 alongside Stall → StallCount=0 next cycle.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared widths and control-bit positions for the MIPS pipeline registers.
// Default field widths plus bit indices inside the WB, M and EX control groups.
package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int EX_W   = 4;

    // WB group
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // M group
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    // EX group: {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;

endpackage

// File: rtl/pipe_field_reg.sv
// Field register with async reset, synchronous clear and load enable.
// Ports: Clk, Rst (async, high), En (load), Clr (sync clear, beats En), D, Q.
module pipe_field_reg
    import mips_pipe_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic         Clr,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Clear wins over enable so a flush lands even while stalled.
    always_comb begin
        q_d = q_q;
        if (Clr) begin
            q_d = '0;
        end else if (En) begin
            q_d = D;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with valid bit, stall hold, flush bubble and
// saturating stall/flush counters.
// Ports: Clk, Rst (async high), Stall, Flush, CountClr, decode-side *_in
// fields, registered *_out fields, StallCount, FlushCount.
module id_ex_pipe_reg
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int REG_W  = mips_pipe_pkg::REG_W,
    parameter int WB_W   = mips_pipe_pkg::WB_W,
    parameter int M_W    = mips_pipe_pkg::M_W,
    parameter int EX_W   = mips_pipe_pkg::EX_W,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              CountClr,
    input  logic              Valid_in,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ReadData1_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic [DATA_W-1:0] SignExtend_in,
    input  logic [REG_W-1:0]  Rs_in,
    input  logic [REG_W-1:0]  Rt_in,
    input  logic [REG_W-1:0]  Rd_in,
    input  logic [WB_W-1:0]   ControlWB_in,
    input  logic [M_W-1:0]    ControlM_in,
    input  logic [EX_W-1:0]   ControlEX_in,
    output logic              Valid_out,
    output logic [DATA_W-1:0] PC_out,
    output logic [DATA_W-1:0] ReadData1_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] SignExtend_out,
    output logic [REG_W-1:0]  Rs_out,
    output logic [REG_W-1:0]  Rt_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic [WB_W-1:0]   ControlWB_out,
    output logic [M_W-1:0]    ControlM_out,
    output logic [EX_W-1:0]   ControlEX_out,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int DW = 4 * DATA_W + 3 * REG_W;
    localparam int CW = WB_W + M_W + EX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic          load_en;
    logic          ctl_clr;
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;
    logic [CW-1:0] ctl_d;
    logic [CW-1:0] ctl_q;

    assign load_en = !Stall;
    // Invalid instruction loads a zero control word; held while stalled.
    assign ctl_clr = Flush | (!Valid_in & !Stall);

    assign data_d = {PC_in, ReadData1_in, ReadData2_in, SignExtend_in,
                     Rs_in, Rt_in, Rd_in};
    assign ctl_d  = {ControlWB_in, ControlM_in, ControlEX_in};

    pipe_field_reg #(.W(DW)) u_data (
        .Clk (Clk),
        .Rst (Rst),
        .En  (load_en),
        .Clr (Flush),
        .D   (data_d),
        .Q   (data_q)
    );

    pipe_field_reg #(.W(CW)) u_ctl (
        .Clk (Clk),
        .Rst (Rst),
        .En  (load_en),
        .Clr (ctl_clr),
        .D   (ctl_d),
        .Q   (ctl_q)
    );

    pipe_field_reg #(.W(1)) u_valid (
        .Clk (Clk),
        .Rst (Rst),
        .En  (load_en),
        .Clr (Flush),
        .D   (Valid_in),
        .Q   (Valid_out)
    );

    assign {PC_out, ReadData1_out, ReadData2_out, SignExtend_out,
            Rs_out, Rt_out, Rd_out} = data_q;
    assign {ControlWB_out, ControlM_out, ControlEX_out} = ctl_q;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (CountClr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (Stall && !Flush && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (Flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: default-width DUT plus a CNT_W=2
// copy on the same inputs for counter saturation.
module tb_id_ex_pipe_reg;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Stall, Flush, CountClr, Valid_in;
    logic [31:0] PC_in, RD1_in, RD2_in, SE_in;
    logic [4:0]  Rs_in, Rt_in, Rd_in;
    logic [1:0]  WB_in;
    logic [2:0]  M_in;
    logic [3:0]  EX_in;

    logic        Valid_out;
    logic [31:0] PC_out, RD1_out, RD2_out, SE_out;
    logic [4:0]  Rs_out, Rt_out, Rd_out;
    logic [1:0]  WB_out;
    logic [2:0]  M_out;
    logic [3:0]  EX_out;
    logic [15:0] StallCount, FlushCount;

    logic        s_Valid_out;
    logic [31:0] s_PC_out, s_RD1_out, s_RD2_out, s_SE_out;
    logic [4:0]  s_Rs_out, s_Rt_out, s_Rd_out;
    logic [1:0]  s_WB_out;
    logic [2:0]  s_M_out;
    logic [3:0]  s_EX_out;
    logic [1:0]  s_StallCount, s_FlushCount;

    int n_chk = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    id_ex_pipe_reg u_dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .CountClr(CountClr), .Valid_in(Valid_in),
        .PC_in(PC_in), .ReadData1_in(RD1_in), .ReadData2_in(RD2_in),
        .SignExtend_in(SE_in), .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
        .ControlWB_in(WB_in), .ControlM_in(M_in), .ControlEX_in(EX_in),
        .Valid_out(Valid_out), .PC_out(PC_out), .ReadData1_out(RD1_out),
        .ReadData2_out(RD2_out), .SignExtend_out(SE_out),
        .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out),
        .ControlWB_out(WB_out), .ControlM_out(M_out),
        .ControlEX_out(EX_out),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    id_ex_pipe_reg #(.CNT_W(2)) u_sat (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .CountClr(CountClr), .Valid_in(Valid_in),
        .PC_in(PC_in), .ReadData1_in(RD1_in), .ReadData2_in(RD2_in),
        .SignExtend_in(SE_in), .Rs_in(Rs_in), .Rt_in(Rt_in), .Rd_in(Rd_in),
        .ControlWB_in(WB_in), .ControlM_in(M_in), .ControlEX_in(EX_in),
        .Valid_out(s_Valid_out), .PC_out(s_PC_out),
        .ReadData1_out(s_RD1_out), .ReadData2_out(s_RD2_out),
        .SignExtend_out(s_SE_out),
        .Rs_out(s_Rs_out), .Rt_out(s_Rt_out), .Rd_out(s_Rd_out),
        .ControlWB_out(s_WB_out), .ControlM_out(s_M_out),
        .ControlEX_out(s_EX_out),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1;
        Stall = 0; Flush = 0; CountClr = 0; Valid_in = 0;
        PC_in = 0; RD1_in = 0; RD2_in = 0; SE_in = 0;
        Rs_in = 0; Rt_in = 0; Rd_in = 0;
        WB_in = 0; M_in = 0; EX_in = 0;
        #3;
        check("init_valid", {63'd0, Valid_out}, 64'd0);
        check("init_pc", {32'd0, PC_out}, 64'd0);
        tick();

        // nonzero inputs, load then one stall cycle
        Rst = 1'b0;
        Valid_in = 1; PC_in = 32'h100; RD1_in = 32'h1111_2222;
        RD2_in = 32'h3333_4444; SE_in = 32'hFFFF_FFF0;
        Rs_in = 5'd1; Rt_in = 5'd2; Rd_in = 5'd3;
        WB_in = 2'b10; M_in = 3'b101; EX_in = 4'b1001;
        tick();
        check("load_pc", {32'd0, PC_out}, 64'h100);
        Stall = 1;
        tick();
        check("pre_rst_stallcnt", {48'd0, StallCount}, 64'd1);
        Stall = 0;

        // async reset mid-cycle
        Rst = 1'b1;
        #2;
        check("rst_valid", {63'd0, Valid_out}, 64'd0);
        check("rst_pc", {32'd0, PC_out}, 64'd0);
        check("rst_rd1", {32'd0, RD1_out}, 64'd0);
        check("rst_ctl", {55'd0, WB_out, M_out, EX_out}, 64'd0);
        check("rst_stallcnt", {48'd0, StallCount}, 64'd0);
        Rst = 1'b0;
        PC_in = 32'h10;
        tick();
        check("post_rst_pc", {32'd0, PC_out}, 64'h10);
        check("post_rst_valid", {63'd0, Valid_out}, 64'd1);

        // pass-through
        RD1_in = 32'hDEAD_BEEF; Rt_in = 5'd9; WB_in = 2'b11;
        tick();
        check("pt_rd1", {32'd0, RD1_out}, 64'hDEAD_BEEF);
        check("pt_rt", {59'd0, Rt_out}, 64'd9);
        check("pt_wb", {62'd0, WB_out}, 64'd3);
        check("pt_ex", {60'd0, EX_out}, 64'b1001);
        check("pt_valid", {63'd0, Valid_out}, 64'd1);

        // stall hold, counters cleared on the load edge
        PC_in = 32'h20; CountClr = 1;
        tick();
        CountClr = 0;
        check("st_load", {32'd0, PC_out}, 64'h20);
        Stall = 1;
        PC_in = 32'h24; tick();
        PC_in = 32'h28; tick();
        PC_in = 32'h2C; tick();
        check("st_hold_pc", {32'd0, PC_out}, 64'h20);
        check("st_cnt3", {48'd0, StallCount}, 64'd3);
        Stall = 0;
        tick();
        check("st_release_pc", {32'd0, PC_out}, 64'h2C);
        check("st_cnt_keep", {48'd0, StallCount}, 64'd3);

        // flush with stall
        Stall = 1; Flush = 1;
        tick();
        check("fl_valid", {63'd0, Valid_out}, 64'd0);
        check("fl_ctl", {55'd0, WB_out, M_out, EX_out}, 64'd0);
        check("fl_pc", {32'd0, PC_out}, 64'd0);
        check("fl_rd1", {32'd0, RD1_out}, 64'd0);
        check("fl_cnt", {48'd0, FlushCount}, 64'd1);
        check("fl_stallcnt", {48'd0, StallCount}, 64'd3);
        Flush = 0;
        tick();
        check("bubble_hold_valid", {63'd0, Valid_out}, 64'd0);
        check("bubble_hold_pc", {32'd0, PC_out}, 64'd0);
        check("bubble_stallcnt", {48'd0, StallCount}, 64'd4);

        // invalid instruction
        Stall = 0; Valid_in = 0; M_in = 3'b010; RD2_in = 32'h1234_5678;
        tick();
        check("inv_m", {61'd0, M_out}, 64'd0);
        check("inv_wb", {62'd0, WB_out}, 64'd0);
        check("inv_rd2", {32'd0, RD2_out}, 64'h1234_5678);
        check("inv_valid", {63'd0, Valid_out}, 64'd0);
        Valid_in = 1;
        tick();
        check("val_m", {61'd0, M_out}, 64'b010);

        // saturation on the 2-bit counter copy
        CountClr = 1;
        tick();
        CountClr = 0;
        Stall = 1;
        repeat (3) tick();
        check("sat_s3", {62'd0, s_StallCount}, 64'd3);
        repeat (3) tick();
        check("sat_s6", {62'd0, s_StallCount}, 64'd3);
        check("wide_s6", {48'd0, StallCount}, 64'd6);
        CountClr = 1;
        tick();
        check("clr_s", {62'd0, s_StallCount}, 64'd0);
        check("clr_wide", {48'd0, StallCount}, 64'd0);
        CountClr = 0;
        tick();
        check("after_clr_s", {62'd0, s_StallCount}, 64'd1);
        Stall = 0; Flush = 1;
        repeat (5) tick();
        check("sat_f", {62'd0, s_FlushCount}, 64'd3);
        check("wide_f", {48'd0, FlushCount}, 64'd5);
        Flush = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
